// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O responder for the 0xFFFFxxxx window: LED/7-seg registers, debounced
// switches and button with press latch, free-running cycle counter and 8-digit display scanner.
module mmio_io_responder #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned SCAN_CYCLES     = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        ioRead,
   input  logic        ioWrite,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic [15:0] sw,
   input  logic        btn,
   output logic [15:0] led,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_cat
);

   localparam logic [31:0] ADDR_LED = 32'hFFFF_FC00;
   localparam logic [31:0] ADDR_SW  = 32'hFFFF_FC10;
   localparam logic [31:0] ADDR_BTN = 32'hFFFF_FC20;
   localparam logic [31:0] ADDR_SEG = 32'hFFFF_FC30;
   localparam logic [31:0] ADDR_CNT = 32'hFFFF_FC40;

   localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned SW_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [DW-1:0]   DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW_W-1:0] SCAN_LAST = SW_W'(SCAN_CYCLES - 1);

   logic [31:0]     seg_data;
   logic [31:0]     cycle_cnt;
   logic [15:0]     sw_meta, sw_sync, sw_stable;
   logic            btn_meta, btn_sync, btn_stable;
   logic            btn_flag;
   logic [DW-1:0]   sw_cnt, btn_cnt;
   logic [SW_W-1:0] scan_cnt;
   logic [2:0]      digit_idx;

   logic wr_led, wr_seg, wr_cnt, rd_btn;
   logic sw_load, btn_load, btn_rise;

   assign wr_led = ioWrite && (addr == ADDR_LED);
   assign wr_seg = ioWrite && (addr == ADDR_SEG);
   assign wr_cnt = ioWrite && (addr == ADDR_CNT);
   assign rd_btn = ioRead  && (addr == ADDR_BTN);

   assign sw_load  = (sw_sync != sw_stable) && (sw_cnt == DEB_LAST);
   assign btn_load = (btn_sync != btn_stable) && (btn_cnt == DEB_LAST);
   assign btn_rise = btn_load && !btn_stable;

   function automatic logic [7:0] hex7seg(input logic [3:0] d);
      logic [7:0] c;
      case (d)
         4'h0: c = 8'hC0;
         4'h1: c = 8'hF9;
         4'h2: c = 8'hA4;
         4'h3: c = 8'hB0;
         4'h4: c = 8'h99;
         4'h5: c = 8'h92;
         4'h6: c = 8'h82;
         4'h7: c = 8'hF8;
         4'h8: c = 8'h80;
         4'h9: c = 8'h90;
         4'hA: c = 8'h88;
         4'hB: c = 8'h83;
         4'hC: c = 8'hC6;
         4'hD: c = 8'hA1;
         4'hE: c = 8'h86;
         default: c = 8'h8E;
      endcase
      return c;
   endfunction

   always_comb begin
      rdata = '0;
      if (ioRead) begin
         case (addr)
            ADDR_LED: rdata = {16'h0000, led};
            ADDR_SW:  rdata = {16'h0000, sw_stable};
            ADDR_BTN: rdata = {30'd0, btn_stable, btn_flag};
            ADDR_SEG: rdata = seg_data;
            ADDR_CNT: rdata = cycle_cnt;
            default:  rdata = '0;
         endcase
      end
   end

   // Bus-visible registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led       <= '0;
         seg_data  <= '0;
         cycle_cnt <= '0;
         btn_flag  <= 1'b0;
      end else begin
         if (wr_led) led <= wdata[15:0];
         if (wr_seg) seg_data <= wdata;
         cycle_cnt <= wr_cnt ? 32'd0 : cycle_cnt + 32'd1;
         // A press landing on the clearing read must not be lost
         if (btn_rise)    btn_flag <= 1'b1;
         else if (rd_btn) btn_flag <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_meta   <= '0;
         sw_sync   <= '0;
         sw_stable <= '0;
         sw_cnt    <= '0;
      end else begin
         sw_meta <= sw;
         sw_sync <= sw_meta;
         if (sw_sync == sw_stable) begin
            sw_cnt <= '0;
         end else if (sw_load) begin
            sw_stable <= sw_sync;
            sw_cnt    <= '0;
         end else begin
            sw_cnt <= sw_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_meta   <= 1'b0;
         btn_sync   <= 1'b0;
         btn_stable <= 1'b0;
         btn_cnt    <= '0;
      end else begin
         btn_meta <= btn;
         btn_sync <= btn_meta;
         if (btn_sync == btn_stable) begin
            btn_cnt <= '0;
         end else if (btn_load) begin
            btn_stable <= btn_sync;
            btn_cnt    <= '0;
         end else begin
            btn_cnt <= btn_cnt + 1'b1;
         end
      end
   end

   // Display scanner; outputs lag the index by one register stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt  <= '0;
         digit_idx <= '0;
         seg_an    <= 8'hFF;
         seg_cat   <= 8'hFF;
      end else begin
         if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end
         seg_an  <= ~(8'd1 << digit_idx);
         seg_cat <= hex7seg(seg_data[{digit_idx, 2'b00} +: 4]);
      end
   end

endmodule

// File: tb/tb_mmio_io_responder.sv
// Self-checking bench for mmio_io_responder: vector table, hand-written debounce/button/scan
// sequences, and randomized bus traffic against a register-level reference model.
module tb_mmio_io_responder;

   localparam logic [31:0] A_LED = 32'hFFFF_FC00;
   localparam logic [31:0] A_SW  = 32'hFFFF_FC10;
   localparam logic [31:0] A_BTN = 32'hFFFF_FC20;
   localparam logic [31:0] A_SEG = 32'hFFFF_FC30;
   localparam logic [31:0] A_CNT = 32'hFFFF_FC40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] addr = '0;
   logic        ioRead = 1'b0;
   logic        ioWrite = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [15:0] sw = '0;
   logic        btn = 1'b0;
   logic [15:0] led;
   logic [7:0]  seg_an;
   logic [7:0]  seg_cat;

   mmio_io_responder #(
      .DEBOUNCE_CYCLES(4),
      .SCAN_CYCLES    (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .addr   (addr),
      .ioRead (ioRead),
      .ioWrite(ioWrite),
      .wdata  (wdata),
      .rdata  (rdata),
      .sw     (sw),
      .btn    (btn),
      .led    (led),
      .seg_an (seg_an),
      .seg_cat(seg_cat)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // Reference model state
   logic [15:0] led_m = '0;
   logic [31:0] seg_m = '0;
   logic [15:0] sw_m  = '0;
   logic [1:0]  btn_m = '0;
   logic [31:0] cnt_m;

   always @(posedge clk or posedge rst) begin
      if (rst) cnt_m <= 0;
      else if (ioWrite && addr == A_CNT) cnt_m <= 0;
      else cnt_m <= cnt_m + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] seg_lut(input logic [3:0] d);
      logic [7:0] t [16];
      t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      return t[d];
   endfunction

   function automatic logic [31:0] exp_read(input logic rd, input logic [31:0] a);
      if (!rd) return 0;
      if (a == A_LED) return {16'h0, led_m};
      if (a == A_SW)  return {16'h0, sw_m};
      if (a == A_BTN) return {30'd0, btn_m};
      if (a == A_SEG) return seg_m;
      if (a == A_CNT) return cnt_m;
      return 0;
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d);
      if (a == A_LED) led_m = d[15:0];
      if (a == A_SEG) seg_m = d;
   endtask

   // One bus cycle: drive at negedge, optionally check rdata, then let the posedge commit
   task automatic step(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input bit chk, input logic [31:0] exp, input string name);
      @(negedge clk);
      ioRead = rd; ioWrite = wr; addr = a; wdata = wd;
      #1;
      if (chk) check(name, rdata, exp);
      @(posedge clk);
      if (wr) model_write(a, wd);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, "");
   endtask

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [15:0] exp_led;
   } vec_t;

   vec_t vecs [16];

   initial begin
      vecs[0]  = '{1'b1, 1'b0, A_LED, 32'h0, 32'h0, 16'h0};
      vecs[1]  = '{1'b1, 1'b0, A_SW,  32'h0, 32'h0, 16'h0};
      vecs[2]  = '{1'b1, 1'b0, A_BTN, 32'h0, 32'h0, 16'h0};
      vecs[3]  = '{1'b1, 1'b0, A_SEG, 32'h0, 32'h0, 16'h0};
      vecs[4]  = '{1'b0, 1'b1, A_LED, 32'hABCD_1234, 32'h0, 16'h0};
      vecs[5]  = '{1'b1, 1'b0, A_LED, 32'h0, 32'h0000_1234, 16'h1234};
      vecs[6]  = '{1'b0, 1'b1, 32'hFFFF_FC04, 32'hFFFF_FFFF, 32'h0, 16'h1234};
      vecs[7]  = '{1'b1, 1'b0, A_LED, 32'h0, 32'h0000_1234, 16'h1234};
      vecs[8]  = '{1'b1, 1'b0, 32'hFFFF_FC04, 32'h0, 32'h0, 16'h1234};
      vecs[9]  = '{1'b0, 1'b1, 32'h0000_FC00, 32'h0000_5555, 32'h0, 16'h1234};
      vecs[10] = '{1'b1, 1'b0, A_LED, 32'h0, 32'h0000_1234, 16'h1234};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_FC00, 32'h0, 32'h0, 16'h1234};
      vecs[12] = '{1'b0, 1'b1, A_SEG, 32'h7654_3210, 32'h0, 16'h1234};
      vecs[13] = '{1'b1, 1'b0, A_SEG, 32'h0, 32'h7654_3210, 16'h1234};
      vecs[14] = '{1'b0, 1'b0, A_LED, 32'h0, 32'h0, 16'h1234};
      vecs[15] = '{1'b1, 1'b0, 32'hFFFF_FC50, 32'h0, 32'h0, 16'h1234};
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a_pool [8];
      int          prev_idx, dwell, idx;
      logic [7:0]  seen;

      a_pool = '{A_LED, A_SW, A_BTN, A_SEG, A_CNT, 32'hFFFF_FC04, 32'h0000_FC00, 32'hFFFF_FC50};

      // Reset state
      #12;
      check("rst_seg_an", {24'h0, seg_an}, 32'hFF);
      check("rst_seg_cat", {24'h0, seg_cat}, 32'hFF);
      check("rst_led", {16'h0, led}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      step(1'b1, 1'b0, A_CNT, 32'h0, 1'b1, 32'd3, "cnt_after_reset");

      // Vector table
      foreach (vecs[i]) begin
         @(negedge clk);
         ioRead = vecs[i].rd; ioWrite = vecs[i].wr; addr = vecs[i].addr; wdata = vecs[i].wdata;
         #1;
         check($sformatf("tbl%0d_rdata", i), rdata, vecs[i].exp_rdata);
         check($sformatf("tbl%0d_led", i), {16'h0, led}, {16'h0, vecs[i].exp_led});
         @(posedge clk);
         if (vecs[i].wr) model_write(vecs[i].addr, vecs[i].wdata);
      end

      // Counter clear: write wins over increment
      step(1'b0, 1'b1, A_CNT, 32'h1234, 1'b0, 32'h0, "");
      step(1'b1, 1'b0, A_CNT, 32'h0, 1'b1, 32'd0, "cnt_clear_0");
      step(1'b1, 1'b0, A_CNT, 32'h0, 1'b1, 32'd1, "cnt_clear_1");

      // Switch debounce latency: new value visible after exactly 6 edges
      @(negedge clk);
      sw = 16'h00A5;
      for (int k = 1; k <= 6; k++) begin
         step(1'b1, 1'b0, A_SW, 32'h0, (k >= 5), (k == 6) ? 32'h00A5 : 32'h0, $sformatf("sw_deb_k%0d", k));
      end
      sw_m = 16'h00A5;

      // Two-cycle glitch must be rejected
      @(negedge clk);
      sw = 16'hFFFF;
      idle(2);
      @(negedge clk);
      sw = 16'h00A5;
      idle(8);
      step(1'b1, 1'b0, A_SW, 32'h0, 1'b1, 32'h00A5, "sw_glitch");

      // Button press: flag + stable, read clears flag only
      @(negedge clk);
      btn = 1'b1;
      idle(7);
      step(1'b1, 1'b0, A_BTN, 32'h0, 1'b1, 32'h3, "btn_press");
      step(1'b1, 1'b0, A_BTN, 32'h0, 1'b1, 32'h2, "btn_cleared");
      @(negedge clk);
      btn = 1'b0;
      idle(8);
      step(1'b1, 1'b0, A_BTN, 32'h0, 1'b1, 32'h0, "btn_released");

      // Press edge coincident with a clearing read: set wins
      @(negedge clk);
      btn = 1'b1;
      idle(4);
      step(1'b1, 1'b0, A_BTN, 32'h0, 1'b1, 32'h0, "btn_coinc_pre");
      step(1'b1, 1'b0, A_BTN, 32'h0, 1'b1, 32'h3, "btn_coinc_set");
      step(1'b1, 1'b0, A_BTN, 32'h0, 1'b1, 32'h2, "btn_coinc_clr");
      @(negedge clk);
      btn = 1'b0;
      idle(8);
      step(1'b1, 1'b0, A_BTN, 32'h0, 1'b1, 32'h0, "btn_coinc_rel");

      // Scanner: SEG holds 0x76543210 from the table
      idle(3);
      prev_idx = -1; dwell = 0; seen = '0;
      for (int c = 0; c < 48; c++) begin
         @(negedge clk);
         #1;
         idx = -1;
         for (int i = 0; i < 8; i++) if (seg_an == ~(8'd1 << i)) idx = i;
         total++;
         if (idx < 0) begin
            $display("FAIL scan_an: got %02h expected one active-low digit", seg_an);
         end else begin
            passed++;
            seen[idx] = 1'b1;
            check("scan_cat", {24'h0, seg_cat}, {24'h0, seg_lut(seg_m[idx*4 +: 4])});
            if (idx == prev_idx) begin
               dwell++;
            end else begin
               if (prev_idx >= 0) begin
                  check("scan_next", idx, (prev_idx + 1) % 8);
                  if (dwell > 0 || c > 1) check("scan_dwell", dwell, 2);
               end
               dwell = (prev_idx < 0) ? 0 : 1;
               prev_idx = idx;
            end
            if (idx == 0) check("scan_cat_d0", {24'h0, seg_cat}, 32'hC0);
            if (idx == 1) check("scan_cat_d1", {24'h0, seg_cat}, 32'hF9);
            if (idx == 7) check("scan_cat_d7", {24'h0, seg_cat}, 32'hF8);
         end
      end
      check("scan_all_digits", {24'h0, seen}, 32'hFF);

      // Randomized bus traffic against the model
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a, d;
         logic        rd, wr;
         int          op;
         a  = a_pool[$urandom_range(0, 7)];
         d  = $urandom;
         op = $urandom_range(0, 2);
         rd = (op == 0);
         wr = (op == 1);
         @(negedge clk);
         ioRead = rd; ioWrite = wr; addr = a; wdata = d;
         #1;
         check("rand_rdata", rdata, exp_read(rd, a));
         check("rand_led", {16'h0, led}, {16'h0, led_m});
         @(posedge clk);
         if (wr) model_write(a, d);
      end

      // Asynchronous reset mid-debounce
      @(negedge clk);
      ioRead = 1'b0; ioWrite = 1'b0;
      sw = 16'h1234;
      idle(2);
      #2;
      rst = 1'b1;
      #1;
      check("arst_led", {16'h0, led}, 32'h0);
      check("arst_seg_an", {24'h0, seg_an}, 32'hFF);
      check("arst_seg_cat", {24'h0, seg_cat}, 32'hFF);
      ioRead = 1'b1; addr = A_SEG;
      #1;
      check("arst_seg_data", rdata, 32'h0);
      addr = A_SW;
      #1;
      check("arst_sw", rdata, 32'h0);
      led_m = '0; seg_m = '0; sw_m = '0;
      @(negedge clk);
      rst = 1'b0;
      ioRead = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step(1'b1, 1'b0, A_SW, 32'h0, (k >= 5), (k == 6) ? 32'h1234 : 32'h0, $sformatf("arst_deb_k%0d", k));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
